// File: rtl/serial_shift_sched.sv
// Two-requester round-robin serializer: grants one word per frame and shifts
// it out MSB first, one bit every DIV clocks, with a single gap cycle between frames.
module serial_shift_sched #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             frame,
  output logic             grant_id,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, n_state;
  logic [WIDTH-1:0] sreg, n_sreg;
  logic [BW-1:0]    bits, n_bits;
  logic [DW-1:0]    div, n_div;
  logic             prio, n_prio;
  logic             n_grant;

  // Reset gates ready so no handshake can complete while held in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && state == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || !prio);
      req1_ready = req1_valid && (!req0_valid || prio);
    end
  end

  always_comb begin
    n_state = state;
    n_sreg  = sreg;
    n_bits  = bits;
    n_div   = div;
    n_prio  = prio;
    n_grant = grant_id;
    unique case (state)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          n_state = SHIFT;
          n_sreg  = req1_ready ? req1_data : req0_data;
          n_grant = req1_ready;
          n_bits  = BLAST;
          n_div   = '0;
        end
      end
      SHIFT: begin
        if (div == DLAST) begin
          n_div = '0;
          if (bits == '0) begin
            n_state = GAP;
          end else begin
            n_sreg = sreg << 1;
            n_bits = bits - 1'b1;
          end
        end else begin
          n_div = div + 1'b1;
        end
      end
      GAP: begin
        n_state = IDLE;
        n_prio  = ~grant_id;
      end
      default: n_state = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      bits       <= '0;
      div        <= '0;
      prio       <= 1'b0;
      grant_id   <= 1'b0;
      serial_out <= 1'b0;
      frame      <= 1'b0;
      shift_en   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= n_state;
      sreg       <= n_sreg;
      bits       <= n_bits;
      div        <= n_div;
      prio       <= n_prio;
      grant_id   <= n_grant;
      serial_out <= (n_state == SHIFT) && n_sreg[WIDTH-1];
      frame      <= (n_state == SHIFT);
      shift_en   <= (n_state == SHIFT) && (n_div == DLAST);
      done       <= (n_state == GAP);
    end
  end

endmodule

// File: tb/tb_serial_shift_sched.sv
// Randomized bench for serial_shift_sched: a frame-level model predicts
// the winner, every frame cycle's outputs, the gap pulse and priority.
module tb_serial_shift_sched;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v0, v1, r0, r1;
  logic [W-1:0] d0, d1;
  logic         so, sen, frm, gid, dn;

  logic         fv0, fr0, fr1, fso, fsen, ffrm, fgid, fdn;
  logic [W-1:0] fd0;

  int total = 0;
  int bad   = 0;
  bit prio  = 1'b0;

  always #5 clk = ~clk;

  serial_shift_sched #(.WIDTH(W), .DIV(D)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .serial_out(so), .shift_en(sen), .frame(frm),
    .grant_id(gid), .done(dn)
  );

  serial_shift_sched #(.WIDTH(W), .DIV(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fv0), .req0_data(fd0), .req0_ready(fr0),
    .req1_valid(1'b0), .req1_data('0), .req1_ready(fr1),
    .serial_out(fso), .shift_en(fsen), .frame(ffrm),
    .grant_id(fgid), .done(fdn)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {frame, serial_out, shift_en, done, req0_ready, req1_ready, grant_id}
  function automatic logic [31:0] obs();
    return {25'd0, frm, so, sen, dn, r0, r1, gid};
  endfunction

  function automatic logic [31:0] pack(bit f, bit s, bit e, bit n,
                                       bit a, bit b, bit g);
    return {25'd0, f, s, e, n, a, b, g};
  endfunction

  // Called at a negedge in IDLE; runs one full frame plus gap.
  task automatic round(input bit a, input bit b,
                       input logic [W-1:0] x0, input logic [W-1:0] x1);
    bit w;
    logic [W-1:0] word;
    w = (a && b) ? prio : b;
    v0 = a; v1 = b; d0 = x0; d1 = x1;
    word = w ? x1 : x0;
    #1;
    chk("grant", {30'd0, r0, r1}, {30'd0, !w, w});
    chk("idle_done", {31'd0, dn}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    d0 = W'($urandom); d1 = W'($urandom);
    for (int k = 0; k < W * D; k++) begin
      chk($sformatf("frm%0d", k), obs(),
          pack(1, word[W - 1 - k / D], (k % D) == D - 1, 0, 0, 0, w));
      @(negedge clk);
    end
    v0 = 1'($urandom); v1 = 1'($urandom);
    #1;
    chk("gap", obs(), pack(0, 0, 0, 1, 0, 0, w));
    prio = ~w;
    @(negedge clk);
  endtask

  initial begin
    bit a, b;
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    fv0 = 1'b0; fd0 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", obs(), pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    round(1, 0, 8'hA5, 8'h00);
    round(1, 1, 8'h0F, 8'hF0);
    round(1, 1, 8'h0F, 8'hF0);
    round(1, 1, 8'h0F, 8'hF0);
    round(0, 1, 8'h00, 8'h01);
    round(0, 1, 8'h00, 8'h80);
    round(0, 1, 8'h00, 8'hFF);
    round(1, 0, 8'h5A, 8'h00);

    for (int i = 0; i < 20; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      if (!a && !b) a = 1'b1;
      round(a, b, W'($urandom), W'($urandom));
    end

    // Abort a frame mid-way; priority must return to requester 0.
    v0 = 1'b1; v1 = 1'b0; d0 = 8'hA5;
    #1;
    chk("abort_grant", {31'd0, r0}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort", {31'd0, frm}, 32'd1);
    v0 = 1'b1; v1 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort", obs(), pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("abort_nodone", obs(), pack(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    prio = 1'b0;
    round(1, 1, 8'h3C, 8'hC3);

    // DIV=1: shift_en stays high for the whole frame.
    fv0 = 1'b1; fd0 = 8'h3C;
    #1;
    chk("fast_rdy", {31'd0, fr0}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    fv0 = 1'b0; fd0 = 8'hFF;
    for (int k = 0; k < W; k++) begin
      chk($sformatf("fast%0d", k), {28'd0, ffrm, fsen, fso, fdn},
          {28'd0, 1'b1, 1'b1, 1'(8'h3C >> (W - 1 - k)), 1'b0});
      @(negedge clk);
    end
    chk("fast_gap", {28'd0, ffrm, fsen, fso, fdn}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
